// File: rtl/prio_encoder8_3.sv
// prio_encoder8_3: registered 8-to-3 priority encoder with a valid/ready output.
// Request bits are accumulated into a pending register. Each accepted index
// clears its pending bit, and the next index is presented without a bubble.
// The default build uses fixed priority, where the highest index wins.
// Defining PRIO_ENCODER8_3_ROUND_ROBIN_EN switches selection to round-robin.
// In that build the scan starts just past the most recently accepted index.

module prio_encoder8_3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_idx,
    output logic [7:0] pending,
    output logic       multi
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state_q;
    logic [2:0] idx_q;
    logic [7:0] pending_q;
    logic       multi_q;

    logic       acc;
    logic [7:0] clr;
    logic [7:0] rem;
    logic [7:0] pending_d;
    logic       multi_d;
    logic [2:0] sel_d;

    // Handshake and the pending-bit bookkeeping.
    // A same-cycle request on the accepted bit re-arms that bit,
    // but only rem feeds selection.
    always_comb begin
        acc       = (state_q == PRESENT) && out_ready;
        clr       = acc ? (8'd1 << idx_q) : 8'd0;
        rem       = pending_q & ~clr;
        pending_d = rem | req;
        multi_d   = |(pending_d & (pending_d - 8'd1));
    end

`ifdef PRIO_ENCODER8_3_ROUND_ROBIN_EN
    logic [2:0] last_q;
    logic [2:0] scanBase;
    logic [2:0] cand;
    logic       found;

    // Round-robin pick: scan rem upward from one past the latest accepted index, wrapping 7->0.
    always_comb begin
        scanBase = acc ? idx_q : last_q;
        sel_d    = 3'd0;
        cand     = 3'd0;
        found    = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cand = scanBase + 3'(i);
            if (!found && rem[cand]) begin
                sel_d = cand;
                found = 1'b1;
            end
        end
    end

    // The pointer remembers the last index the consumer actually took.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 3'd7;
        end else if (acc) begin
            last_q <= idx_q;
        end
    end
`else
    // Fixed priority: the highest set bit of rem wins, because later loop iterations override earlier ones.
    always_comb begin
        sel_d = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (rem[i]) begin
                sel_d = 3'(i);
            end
        end
    end
`endif

    // Presentation FSM and registered outputs.
    // While stalled, idx_q is frozen even if higher-priority requests arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            pending_q <= 8'h00;
            multi_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            multi_q   <= multi_d;
            case (state_q)
                IDLE: begin
                    if (pending_q != 8'h00) begin
                        idx_q   <= sel_d;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        if (rem != 8'h00) begin
                            idx_q <= sel_d;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = (state_q == PRESENT);
    assign out_idx   = idx_q;
    assign pending   = pending_q;
    assign multi     = multi_q;

endmodule
